decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I decode stage with valid/ready handshakes on both sides.
//  Sits between fetch and execute. Turns a 32-bit instruction into a control bundle
//  with an XLEN-wide sign-extended immediate, and adds LUI/AUIPC plus illegal-instruction
//  detection. Holds load/store bundles until the LSU signals completion, with a wait timeout.
// PARAMETERS
//  XLEN        32   datapath width; immediates and pc are sign-extended/carried at XLEN
//  LS_TIMEOUT  255  max cycles in LS_WAIT before forced abort (0 = no timeout)
//  CNT_W       8    width of LS wait counter; must satisfy 2**CNT_W > LS_TIMEOUT
// PORTS
//  clk_i          in   1     clock
//  rst_ni         in   1     asynchronous active-low reset
//  instr_i        in   32    instruction from fetch
//  pc_i           in   XLEN  pc of instr_i
//  instr_valid_i  in   1     fetch has an instruction
//  instr_ready_o  out  1     stage accepts instr_i this cycle
//  flush_i        in   1     drop held bundle (branch taken / trap)
//  dec_valid_o    out  1     bundle valid toward execute
//  dec_ready_i    in   1     execute consumes bundle
//  load_ready_i   in   1     LSU finished current load/store
//  alu_op_o       out  4     ALU op: ADD0 SLT1 AND2 OR3 XOR4 SLL5 SRL6 SUB7 SRA8 SLTU9 PASSB12
//  reg_write_o, branch_o, jump_o, jalr_o, mem_read_o, mem_write_o, mem_to_reg_o,
//  use_imm_o, use_pc_o, ls_o, illegal_o   out  1 each   registered control flags
//  rs1_o rs2_o rd_o   out  5     register indices
//  funct3_o       out  3     funct3 field
//  imm_o          out  XLEN  sign-extended I/S/B/U/J immediate
//  pc_o           out  XLEN  registered pc
//  ls_timeout_o   out  1     one-cycle pulse when LS wait aborts
// BEHAVIOUR
//  - Reset: state EMPTY; all outputs 0, alu_op_o=0, counter=0.
//  - FSM states:
//    EMPTY: instr_ready_o=1. A handshake registers the decoded bundle -> FULL
//           (latency 1 cycle).
//    FULL: dec_valid_o=1.
//      - dec_ready_i on a non-LS bundle: instr_ready_o=1, allowing back-to-back accept.
//        Stays FULL on accept, else -> EMPTY.
//      - dec_ready_i on a LS bundle: -> LS_WAIT. instr_ready_o=0.
//    LS_WAIT: dec_valid_o=0, ls_o=1, mem_* held, instr_ready_o=0, counter increments.
//      - load_ready_i -> EMPTY; ls_o drops the same edge.
//      - counter==LS_TIMEOUT-1 without load_ready_i -> pulse ls_timeout_o -> EMPTY.
//  - flush_i: in EMPTY/FULL it wins over a same-cycle accept. The bundle is discarded
//    (dec_valid_o=0 next cycle) -> EMPTY. It is ignored in LS_WAIT because the memory
//    op is already in flight.
//  - Immediates (all sign-extended from instr[31]):
//    I = instr[31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0};
//    U = {[31:12],12'b0}; J = {[31],[19:12],[20],[30:21],0}. JALR uses I.
//  - Per-opcode decode:
//    OP-IMM: bit30 selects SRAI vs SRLI.
//    OP: funct7 0100000 selects SUB/SRA.
//    LUI: PASSB, use_imm_o=1.
//    AUIPC: ADD, use_pc_o=1, use_imm_o=1.
//    BRANCH: BEQ/BNE->SUB, BLT/BGE->SLT, BLTU/BGEU->SLTU.
//    LOAD/STORE: ADD with imm, ls_o=1.
//  - Illegal (illegal_o=1; reg_write/mem_*/branch/jump forced 0):
//    - unknown opcode, or instr[1:0]!=11
//    - branch funct3 010/011
//    - OP funct7 not 0000000/0100000, or 0100000 with funct3 not 000/101
//    - SLLI funct7!=0
//    - load funct3 011/110/111; store funct3 >010
//  - Illegal bundles still handshake normally; execute raises the trap.
//  - Counter is CNT_W bits and saturates; with LS_TIMEOUT=0 the timeout is disabled.
// STRUCTURE
//  - decode_pkg: opcode localparams, ALU op encodings, FSM state encoding (EMPTY/FULL/LS_WAIT).
//  - Sub-module decode_comb (parametrised XLEN, purely combinational field/immediate decode
//    + illegal check). decode_stage wraps it with the FSM, output register and wait counter.
// TESTING
//  - addi x1,x2,-1 (0xFFF10093), dec_ready_i=1 -> next cycle dec_valid_o=1,
//    alu_op=0, imm_o=0xFFFFFFFF, rd=1.
//  - lui x5,0x12345 (0x123452B7) -> imm_o=0x12345000, alu_op=12, reg_write=1.
//  - lw x3,8(x4), dec_ready_i=1, load_ready_i after 3 cycles -> ls_o=1 for exactly 3
//    cycles, instr_ready_o=0 throughout, then EMPTY.
//  - Store with LS_TIMEOUT=4, load_ready_i never high -> ls_timeout_o pulses once after
//    4 LS_WAIT cycles; next instruction accepted.
//  - Stream of 4 ADDs with dec_ready_i=1 -> one bundle per cycle, no bubbles;
//    dec_ready_i=0 for 2 cycles -> bundle held stable, instr_ready_o=0.
//  - flush_i with instr_valid_i in FULL -> no accept, dec_valid_o=0 next cycle.
//    Opcode 0x0000007F -> illegal_o=1, reg_write_o=0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcodes, ALU op encodings, control bundle and stage FSM states.
package decode_pkg;

  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd   = 4'd0,
    AluSlt   = 4'd1,
    AluAnd   = 4'd2,
    AluOr    = 4'd3,
    AluXor   = 4'd4,
    AluSll   = 4'd5,
    AluSrl   = 4'd6,
    AluSub   = 4'd7,
    AluSra   = 4'd8,
    AluSltu  = 4'd9,
    AluPassB = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    StEmpty,
    StFull,
    StLsWait
  } state_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       use_imm;
    logic       use_pc;
    logic       ls;
    logic       illegal;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
  } ctrl_t;

  // alt turns ADD into SUB and SRL into SRA.
  function automatic alu_op_e f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_if #(
  parameter int unsigned XLEN = 32
);
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic            instr_valid_i;
  logic            instr_ready_o;
  logic            flush_i;
  logic            dec_valid_o;
  logic            dec_ready_i;
  logic            load_ready_i;
  logic [3:0]      alu_op_o;
  logic            reg_write_o;
  logic            branch_o;
  logic            jump_o;
  logic            jalr_o;
  logic            mem_read_o;
  logic            mem_write_o;
  logic            mem_to_reg_o;
  logic            use_imm_o;
  logic            use_pc_o;
  logic            ls_o;
  logic            illegal_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [2:0]      funct3_o;
  logic [XLEN-1:0] imm_o;
  logic [XLEN-1:0] pc_o;
  logic            ls_timeout_o;

  modport slave (
    input  instr_i, pc_i, instr_valid_i, flush_i, dec_ready_i, load_ready_i,
    output instr_ready_o, dec_valid_o, alu_op_o, reg_write_o, branch_o, jump_o, jalr_o,
           mem_read_o, mem_write_o, mem_to_reg_o, use_imm_o, use_pc_o, ls_o, illegal_o,
           rs1_o, rs2_o, rd_o, funct3_o, imm_o, pc_o, ls_timeout_o
  );

  modport master (
    output instr_i, pc_i, instr_valid_i, flush_i, dec_ready_i, load_ready_i,
    input  instr_ready_o, dec_valid_o, alu_op_o, reg_write_o, branch_o, jump_o, jalr_o,
           mem_read_o, mem_write_o, mem_to_reg_o, use_imm_o, use_pc_o, ls_o, illegal_o,
           rs1_o, rs2_o, rd_o, funct3_o, imm_o, pc_o, ls_timeout_o
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I field/immediate decode with illegal-instruction detection.
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  ctrl_t       ctrl;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    ctrl        = '0;
    imm32       = '0;
    ctrl.rs1    = instr_i[19:15];
    ctrl.rs2    = instr_i[24:20];
    ctrl.rd     = instr_i[11:7];
    ctrl.funct3 = funct3;
    ctrl.alu_op = AluAdd;
    case (opcode)
      OpcOpImm: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        imm32          = imm_i;
        ctrl.alu_op    = f3_to_alu(funct3, (funct3 == 3'b101) && instr_i[30]);
        ctrl.illegal   = (funct3 == 3'b001) && (funct7 != F7Base);
      end
      OpcOp: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = f3_to_alu(funct3, funct7 == F7Alt);
        if (funct7 == F7Alt) ctrl.illegal = !(funct3 inside {3'b000, 3'b101});
        else                 ctrl.illegal = (funct7 != F7Base);
      end
      OpcLui: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.alu_op    = AluPassB;
        imm32          = imm_u;
      end
      OpcAuipc: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.use_pc    = 1'b1;
        imm32          = imm_u;
      end
      OpcJal: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.use_pc    = 1'b1;
        imm32          = imm_j;
      end
      OpcJalr: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.use_imm   = 1'b1;
        imm32          = imm_i;
      end
      OpcBranch: begin
        ctrl.branch = 1'b1;
        imm32       = imm_b;
        case (funct3)
          3'b000, 3'b001: ctrl.alu_op = AluSub;
          3'b100, 3'b101: ctrl.alu_op = AluSlt;
          3'b110, 3'b111: ctrl.alu_op = AluSltu;
          default:        ctrl.illegal = 1'b1;
        endcase
      end
      OpcLoad: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.use_imm    = 1'b1;
        ctrl.ls         = 1'b1;
        imm32           = imm_i;
        ctrl.illegal    = funct3 inside {3'b011, 3'b110, 3'b111};
      end
      OpcStore: begin
        ctrl.mem_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.ls        = 1'b1;
        imm32          = imm_s;
        ctrl.illegal   = (funct3 > 3'b010);
      end
      default: ctrl.illegal = 1'b1;
    endcase
    // An illegal bundle must not touch state or memory, nor park the stage in LS wait.
    if (ctrl.illegal) begin
      ctrl.reg_write  = 1'b0;
      ctrl.branch     = 1'b0;
      ctrl.jump       = 1'b0;
      ctrl.jalr       = 1'b0;
      ctrl.mem_read   = 1'b0;
      ctrl.mem_write  = 1'b0;
      ctrl.mem_to_reg = 1'b0;
      ctrl.ls         = 1'b0;
    end
  end

  assign ctrl_o = ctrl;
  assign imm_o  = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: valid/ready on both sides, holds load/store bundles until the
// LSU completes, with an optional wait timeout.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LS_TIMEOUT = 255,
  parameter int unsigned CNT_W      = 8
) (
  input logic     clk_i,
  input logic     rst_ni,
  decode_if.slave bus
);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'((LS_TIMEOUT == 0) ? 0 : LS_TIMEOUT - 1);

  state_e           state_q;
  ctrl_t            ctrl_q;
  logic [XLEN-1:0]  imm_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  logic            instr_ready;
  logic            accept;

  decode_comb #(
    .XLEN(XLEN)
  ) u_decode_comb (
    .instr_i(bus.instr_i),
    .ctrl_o (dec_ctrl),
    .imm_o  (dec_imm)
  );

  // Flush blocks acceptance so a same-cycle instruction is never captured.
  always_comb begin
    instr_ready = 1'b0;
    unique case (state_q)
      StEmpty:  instr_ready = !bus.flush_i;
      StFull:   instr_ready = !bus.flush_i && bus.dec_ready_i && !ctrl_q.ls;
      default:  instr_ready = 1'b0;
    endcase
  end

  assign accept = bus.instr_valid_i && instr_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StEmpty;
      ctrl_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            ctrl_q  <= dec_ctrl;
            imm_q   <= dec_imm;
            pc_q    <= bus.pc_i;
            state_q <= StFull;
          end
        end
        StFull: begin
          if (bus.flush_i) begin
            ctrl_q  <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            state_q <= StEmpty;
          end else if (bus.dec_ready_i) begin
            if (ctrl_q.ls) begin
              cnt_q   <= '0;
              state_q <= StLsWait;
            end else if (accept) begin
              ctrl_q <= dec_ctrl;
              imm_q  <= dec_imm;
              pc_q   <= bus.pc_i;
            end else begin
              ctrl_q  <= '0;
              imm_q   <= '0;
              pc_q    <= '0;
              state_q <= StEmpty;
            end
          end
        end
        StLsWait: begin
          if (bus.load_ready_i || ((LS_TIMEOUT != 0) && (cnt_q == TimeoutLast))) begin
            timeout_q <= !bus.load_ready_i;
            ctrl_q    <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            cnt_q     <= '0;
            state_q   <= StEmpty;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign bus.instr_ready_o = instr_ready;
  assign bus.dec_valid_o   = (state_q == StFull);
  assign bus.alu_op_o      = ctrl_q.alu_op;
  assign bus.reg_write_o   = ctrl_q.reg_write;
  assign bus.branch_o      = ctrl_q.branch;
  assign bus.jump_o        = ctrl_q.jump;
  assign bus.jalr_o        = ctrl_q.jalr;
  assign bus.mem_read_o    = ctrl_q.mem_read;
  assign bus.mem_write_o   = ctrl_q.mem_write;
  assign bus.mem_to_reg_o  = ctrl_q.mem_to_reg;
  assign bus.use_imm_o     = ctrl_q.use_imm;
  assign bus.use_pc_o      = ctrl_q.use_pc;
  assign bus.ls_o          = ctrl_q.ls;
  assign bus.illegal_o     = ctrl_q.illegal;
  assign bus.rs1_o         = ctrl_q.rs1;
  assign bus.rs2_o         = ctrl_q.rs2;
  assign bus.rd_o          = ctrl_q.rd;
  assign bus.funct3_o      = ctrl_q.funct3;
  assign bus.imm_o         = imm_q;
  assign bus.pc_o          = pc_q;
  assign bus.ls_timeout_o  = timeout_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected bundles, a monitor
// pops and compares on every execute-side handshake.
module tb_decode_stage;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  decode_if #(.XLEN(32)) bus ();

  decode_stage #(
    .XLEN      (32),
    .LS_TIMEOUT(4),
    .CNT_W     (8)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  alu;
    logic        rw;
    logic        ill;
    logic        ls;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          to_pulses = 0;
  int          last_wait = 0;
  logic [31:0] pc_ctr = 32'h100;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic send(input logic [31:0] ins, input bit push, input exp_t e);
    int waited = 0;
    bus.instr_i       = ins;
    bus.pc_i          = e.pc;
    bus.instr_valid_i = 1'b1;
    @(negedge clk_i);
    while (!bus.instr_ready_o && waited < 40) begin
      @(negedge clk_i);
      waited++;
    end
    chk({e.name, "_accept"}, bus.instr_ready_o, 1'b1);
    if (bus.instr_ready_o && push) exp_q.push_back(e);
    last_wait = waited;
    @(posedge clk_i);
    #1;
    bus.instr_valid_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins, input string nm, input logic [3:0] alu,
                       input logic rw, input logic ill, input logic ls, input logic [4:0] rd,
                       input logic [31:0] imm, input bit push);
    exp_t e;
    e.name = nm; e.alu = alu; e.rw = rw; e.ill = ill; e.ls = ls; e.rd = rd; e.imm = imm;
    e.pc   = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    send(ins, push, e);
  endtask

  // Monitor: every consumed bundle must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni === 1'b1 && bus.dec_valid_o && bus.dec_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bundle", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_ctrl"},
              {bus.alu_op_o, bus.reg_write_o, bus.illegal_o, bus.ls_o, bus.rd_o},
              {e.alu, e.rw, e.ill, e.ls, e.rd});
          chk({e.name, "_imm"}, bus.imm_o, e.imm);
          chk({e.name, "_pc"}, bus.pc_o, e.pc);
        end
      end
      if (rst_ni === 1'b1 && bus.ls_timeout_o) to_pulses++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ls_cyc;
    int  wsum;
    bit  rdy_bad;
    bit  seen;
    rst_ni            = 1'b0;
    bus.instr_i       = '0;
    bus.pc_i          = '0;
    bus.instr_valid_i = 1'b0;
    bus.flush_i       = 1'b0;
    bus.dec_ready_i   = 1'b0;
    bus.load_ready_i  = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", bus.dec_valid_o, 0);
    chk("rst_alu", bus.alu_op_o, 0);
    chk("rst_imm", bus.imm_o, 0);
    chk("rst_ls", bus.ls_o, 0);
    chk("rst_timeout", bus.ls_timeout_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni          = 1'b1;
    bus.dec_ready_i = 1'b1;

    issue(32'hFFF10093, "addi",    4'd0,  1, 0, 0, 5'd1,  32'hFFFF_FFFF, 1);
    issue(32'h123452B7, "lui",     4'd12, 1, 0, 0, 5'd5,  32'h1234_5000, 1);
    issue(32'h00001197, "auipc",   4'd0,  1, 0, 0, 5'd3,  32'h0000_1000, 1);
    issue(32'h403100B3, "sub",     4'd7,  1, 0, 0, 5'd1,  32'h0000_0000, 1);
    issue(32'h40315093, "srai",    4'd8,  1, 0, 0, 5'd1,  32'h0000_0403, 1);
    issue(32'h00209863, "bne",     4'd7,  0, 0, 0, 5'd16, 32'h0000_0010, 1);
    issue(32'h0000007F, "ill_opc", 4'd0,  0, 1, 0, 5'd0,  32'h0000_0000, 1);
    issue(32'h02000033, "ill_f7",  4'd0,  0, 1, 0, 5'd0,  32'h0000_0000, 1);

    // Back-to-back stream: every ADD must find instr_ready_o high immediately.
    wsum = 0;
    issue(32'h009403B3, "add0", 4'd0, 1, 0, 0, 5'd7,  32'h0, 1); wsum += last_wait;
    issue(32'h00940533, "add1", 4'd0, 1, 0, 0, 5'd10, 32'h0, 1); wsum += last_wait;
    issue(32'h009405B3, "add2", 4'd0, 1, 0, 0, 5'd11, 32'h0, 1); wsum += last_wait;
    issue(32'h00940633, "add3", 4'd0, 1, 0, 0, 5'd12, 32'h0, 1); wsum += last_wait;
    chk("stream_bubbles", wsum, 0);

    // Load held until the LSU answers in the third wait cycle.
    issue(32'h00822183, "lw", 4'd0, 1, 0, 1, 5'd3, 32'h0000_0008, 1);
    ls_cyc  = 0;
    rdy_bad = 1'b0;
    for (int n = 0; n < 20 && ls_cyc < 3; n++) begin
      @(negedge clk_i);
      if (!bus.dec_valid_o && bus.ls_o) begin
        ls_cyc++;
        if (bus.instr_ready_o) rdy_bad = 1'b1;
      end
    end
    bus.load_ready_i = 1'b1;
    @(negedge clk_i);
    chk("lw_wait_cycles", ls_cyc, 3);
    chk("lw_irdy_low", rdy_bad, 0);
    chk("lw_ls_drop", bus.ls_o, 0);
    chk("lw_empty_irdy", bus.instr_ready_o, 1);
    @(posedge clk_i);
    #1;
    bus.load_ready_i = 1'b0;

    // Store with no LSU answer: aborts after four wait cycles.
    issue(32'hFE532E23, "sw", 4'd0, 0, 0, 1, 5'd28, 32'hFFFF_FFFC, 1);
    ls_cyc = 0;
    seen   = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk_i);
      if (!bus.dec_valid_o && bus.ls_o) begin
        ls_cyc++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    chk("sw_wait_cycles", ls_cyc, 4);
    chk("sw_timeout_pulse", bus.ls_timeout_o, 1);
    @(posedge clk_i);
    #1;
    issue(32'hFFF10093, "addi_post_to", 4'd0, 1, 0, 0, 5'd1, 32'hFFFF_FFFF, 1);

    // Execute stalls for two cycles: bundle stays put, fetch is back-pressured.
    repeat (2) @(posedge clk_i);
    #1;
    bus.dec_ready_i = 1'b0;
    issue(32'h009403B3, "add_hold", 4'd0, 1, 0, 0, 5'd7, 32'h0, 1);
    bus.instr_i       = 32'h00940533;
    bus.instr_valid_i = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk_i);
      chk("hold_valid", bus.dec_valid_o, 1);
      chk("hold_rd", bus.rd_o, 5'd7);
      chk("hold_irdy", bus.instr_ready_o, 0);
    end
    @(posedge clk_i);
    #1;
    bus.instr_valid_i = 1'b0;
    bus.dec_ready_i   = 1'b1;

    // Flush in FULL beats a concurrent fetch and discards the held bundle.
    repeat (2) @(posedge clk_i);
    #1;
    bus.dec_ready_i = 1'b0;
    issue(32'h00940533, "add_flushed", 4'd0, 1, 0, 0, 5'd10, 32'h0, 0);
    bus.flush_i       = 1'b1;
    bus.instr_i       = 32'h009405B3;
    bus.instr_valid_i = 1'b1;
    @(negedge clk_i);
    chk("flush_irdy", bus.instr_ready_o, 0);
    @(posedge clk_i);
    #1;
    bus.flush_i       = 1'b0;
    bus.instr_valid_i = 1'b0;
    @(negedge clk_i);
    chk("flush_drop", bus.dec_valid_o, 0);
    @(posedge clk_i);
    #1;
    bus.dec_ready_i = 1'b1;
    issue(32'h123452B7, "lui_post_flush", 4'd12, 1, 0, 0, 5'd5, 32'h1234_5000, 1);

    repeat (4) @(posedge clk_i);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("timeout_pulses", to_pulses, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
